// File: rtl/sd_blk_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_blk_arbiter
// Purpose  : Round-robin arbiter sharing one SD sector port among four drives,
//            with an ack-wait watchdog and a recovery state.
// Revision : 1.0
// ============================================================================
module sd_blk_arbiter #(
    parameter int TMO_W = 24
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       req_rd,
    input  logic [3:0]       req_wr,
    input  logic [3:0][31:0] req_lba,
    input  logic [3:0][7:0]  drv_buff_din,
    output logic [3:0]       drv_ack,
    output logic             sd_rd,
    output logic             sd_wr,
    output logic [31:0]      sd_lba,
    input  logic             sd_ack,
    output logic [7:0]       sd_buff_din,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             tmo_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        XFER    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       last, last_nxt;
    logic [1:0]       grant_nxt;
    logic             op_rd, op_rd_nxt;
    logic [31:0]      lba_nxt;
    logic [TMO_W-1:0] cnt, cnt_nxt;

    logic [3:0]       req;
    logic             pick_vld;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             tmo_hit;

    assign req = req_rd | req_wr;

    // Descending scan so the nearest set bit after 'last' is the one kept.
    always_comb begin
        pick_vld = 1'b0;
        pick     = 2'd0;
        idx      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = last + 2'(i + 1);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    // An ack or a cancel in the final ISSUE cycle takes priority over expiry.
    assign tmo_hit = (state == ISSUE) && !sd_ack && req[grant] && (&cnt);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        grant_nxt = grant;
        op_rd_nxt = op_rd;
        lba_nxt   = sd_lba;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = pick;
                    op_rd_nxt = req_rd[pick];
                    lba_nxt   = req_lba[pick];
                    cnt_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    state_nxt = XFER;
                end else if (!req[grant]) begin
                    state_nxt = IDLE;
                end else if (&cnt) begin
                    state_nxt = RECOVER;
                end else begin
                    cnt_nxt = cnt + TMO_W'(1);
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            RECOVER: begin
                if (!sd_ack && !req[grant]) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            last   <= 2'd3;
            grant  <= 2'd0;
            op_rd  <= 1'b0;
            sd_lba <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            grant  <= grant_nxt;
            op_rd  <= op_rd_nxt;
            sd_lba <= lba_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // The ack is forwarded from its first cycle, including the ISSUE cycle it rises in.
    assign sd_rd       = (state == ISSUE) && op_rd  && !tmo_hit;
    assign sd_wr       = (state == ISSUE) && !op_rd && !tmo_hit;
    assign drv_ack     = (((state == ISSUE) || (state == XFER)) && sd_ack) ? (4'b0001 << grant) : 4'b0000;
    assign busy        = (state != IDLE);
    assign tmo_err     = tmo_hit;
    assign sd_buff_din = drv_buff_din[grant];

endmodule
`default_nettype wire

// File: tb/tb_sd_blk_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_blk_arbiter
// Purpose  : Scoreboard bench for sd_blk_arbiter using directed scenarios.
// Revision : 1.0
// ============================================================================
module tb_sd_blk_arbiter;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [3:0]       req_rd = 4'h0;
    logic [3:0]       req_wr = 4'h0;
    logic [3:0][31:0] req_lba;
    logic [3:0][7:0]  drv_buff_din;
    logic [3:0]       drv_ack;
    logic             sd_rd, sd_wr;
    logic [31:0]      sd_lba;
    logic             sd_ack = 1'b0;
    logic [7:0]       sd_buff_din;
    logic [1:0]       grant;
    logic             busy, tmo_err;

    always #5 CLK = ~CLK;

    sd_blk_arbiter #(.TMO_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
        .drv_buff_din(drv_buff_din), .drv_ack(drv_ack), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_lba(sd_lba), .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .grant(grant),
        .busy(busy), .tmo_err(tmo_err)
    );

    localparam logic [1:0] K_GNT = 2'd0, K_ACK = 2'd1, K_TMO = 2'd2, K_IDL = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  g;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        logic [3:0]  ack;
        logic [7:0]  bd;
    } ev_t;

    ev_t  q[$];
    int   checks = 0;
    int   failures = 0;
    logic busy_q = 1'b0;

    localparam logic [31:0] L0 = 32'h0000_0012, L1 = 32'h0000_2345,
                            L2 = 32'hDEAD_BEEF, L3 = 32'h8000_0003;

    function automatic ev_t mk(input logic [1:0] kind, input logic [1:0] g, input logic rd,
                               input logic wr, input logic [31:0] lba, input logic [3:0] ack,
                               input logic [7:0] bd);
        ev_t e;
        e.kind = kind; e.g = g; e.rd = rd; e.wr = wr; e.lba = lba; e.ack = ack; e.bd = bd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic mon(input string name, input ev_t got);
        ev_t exp;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_%s unexpected event got=%h", name, got);
        end else begin
            exp = q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL sb_%s got=%h exp=%h", name, got, exp);
            end
        end
    endtask

    // Monitor: fixed per-cycle event order is grant, ack, timeout, release.
    always @(negedge CLK) begin
        if (busy && !busy_q)
            mon("grant", mk(K_GNT, grant, sd_rd, sd_wr, sd_lba, 4'h0, sd_buff_din));
        if (drv_ack != 4'h0)
            mon("ack", mk(K_ACK, grant, 1'b0, 1'b0, 32'h0, drv_ack, 8'h0));
        if (tmo_err)
            mon("tmo", mk(K_TMO, grant, sd_rd, sd_wr, 32'h0, 4'h0, 8'h0));
        if (!busy && busy_q)
            mon("idle", mk(K_IDL, grant, 1'b0, 1'b0, 32'h0, 4'h0, 8'h0));
        busy_q = busy;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_grant(input logic [1:0] g, input logic rd, input logic [31:0] lba,
                             input logic [7:0] bd);
        q.push_back(mk(K_GNT, g, rd, !rd, lba, 4'h0, bd));
    endtask

    task automatic exp_ack(input logic [1:0] g, input int n);
        for (int i = 0; i < n; i++)
            q.push_back(mk(K_ACK, g, 1'b0, 1'b0, 32'h0, 4'b0001 << g, 8'h0));
    endtask

    task automatic exp_idle(input logic [1:0] g);
        q.push_back(mk(K_IDL, g, 1'b0, 1'b0, 32'h0, 4'h0, 8'h0));
    endtask

    // Host model: wait for a request, ack for n cycles, dropping the listed requests.
    task automatic host(input int n, input logic [3:0] drop);
        int w = 0;
        while (!(sd_rd || sd_wr) && w < 40) begin
            tick();
            w++;
        end
        chk("host_wait", 64'(sd_rd | sd_wr), 64'd1);
        sd_ack = 1'b1;
        req_rd = req_rd & ~drop;
        req_wr = req_wr & ~drop;
        repeat (n) tick();
        sd_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        req_lba[0] = L0; req_lba[1] = L1; req_lba[2] = L2; req_lba[3] = L3;
        drv_buff_din[0] = 8'hA0; drv_buff_din[1] = 8'hA1;
        drv_buff_din[2] = 8'hA2; drv_buff_din[3] = 8'hA3;

        repeat (2) tick();
        chk("reset_outputs", 64'({grant, sd_rd, sd_wr, sd_lba, tmo_err, busy, drv_ack}), 64'd0);
        RESET = 1'b0;
        tick();

        // Single read with a 3-cycle ack
        exp_grant(2'd0, 1'b1, L0, 8'hA0); exp_ack(2'd0, 3); exp_idle(2'd0);
        req_rd = 4'b0001;
        tick();
        chk("t1_latency_rd", 64'(sd_rd), 64'd1);
        chk("t1_lba", 64'(sd_lba), 64'(L0));
        sd_ack = 1'b1;
        tick();
        chk("t1_rd_drop", 64'(sd_rd), 64'd0);
        tick(); tick();
        sd_ack = 1'b0; req_rd = 4'b0000;
        chk("t1_busy_hold", 64'(busy), 64'd1);
        tick();
        chk("t1_busy_fall", 64'(busy), 64'd0);

        // Fresh arbitration, all drives writing: 0,1,2,3,0
        RESET = 1'b1; tick(); RESET = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            exp_grant(2'(i), 1'b0, req_lba[i % 4], drv_buff_din[i % 4]);
            exp_ack(2'(i), 2);
            exp_idle(2'(i));
        end
        req_wr = 4'hF;
        for (int i = 0; i < 4; i++) host(2, 4'h0);
        host(2, 4'hF);

        // Read wins over write on the same drive
        exp_grant(2'd2, 1'b1, L2, 8'hA2); exp_ack(2'd2, 1); exp_idle(2'd2);
        req_rd = 4'b0100; req_wr = 4'b0100;
        host(1, 4'b0100);

        // Watchdog expiry, recovery, then round-robin continues past drive 1
        exp_grant(2'd1, 1'b1, L1, 8'hA1);
        q.push_back(mk(K_TMO, 2'd1, 1'b0, 1'b0, 32'h0, 4'h0, 8'h0));
        exp_idle(2'd1);
        exp_grant(2'd2, 1'b1, L2, 8'hA2); exp_ack(2'd2, 1); exp_idle(2'd2);
        exp_grant(2'd0, 1'b1, L0, 8'hA0); exp_ack(2'd0, 1); exp_idle(2'd0);
        tick(); tick();
        req_rd = 4'b0010;
        tick();
        chk("t4_issue_rd", 64'(sd_rd), 64'd1);
        repeat (14) tick();
        chk("t4_no_tmo_early", 64'(tmo_err), 64'd0);
        tick();
        chk("t4_tmo_pulse", 64'({tmo_err, sd_rd}), 64'b10);
        tick();
        chk("t4_recover", 64'({busy, tmo_err, sd_rd}), 64'b100);
        req_rd = 4'b0111; sd_ack = 1'b1;
        tick(); tick();
        chk("t4_no_ack_recover", 64'(drv_ack), 64'd0);
        sd_ack = 1'b0;
        tick();
        chk("t4_still_recover", 64'(busy), 64'd1);
        req_rd = 4'b0101;
        tick();
        chk("t4_released", 64'(busy), 64'd0);
        host(1, 4'b0100);
        host(1, 4'b0001);

        // Cancel in ISSUE leaves 'last' untouched: drive 3 beats drive 0
        exp_grant(2'd3, 1'b0, L3, 8'hA3); exp_idle(2'd3);
        exp_grant(2'd3, 1'b0, L3, 8'hA3); exp_ack(2'd3, 1); exp_idle(2'd3);
        exp_grant(2'd0, 1'b0, L0, 8'hA0); exp_ack(2'd0, 1); exp_idle(2'd0);
        tick(); tick();
        req_wr = 4'b1000;
        tick();
        chk("t5_issue_wr", 64'(sd_wr), 64'd1);
        req_wr = 4'b0000;
        tick();
        chk("t5_cancel", 64'({busy, drv_ack}), 64'd0);
        req_wr = 4'b1001;
        host(1, 4'b1000);
        host(1, 4'b0001);

        // Reset during XFER, then drive 0 is searched first again
        exp_grant(2'd1, 1'b1, L1, 8'hA1); exp_ack(2'd1, 1); exp_idle(2'd0);
        exp_grant(2'd0, 1'b1, L0, 8'hA0); exp_ack(2'd0, 1); exp_idle(2'd0);
        exp_grant(2'd1, 1'b1, L1, 8'hA1); exp_ack(2'd1, 1); exp_idle(2'd1);
        tick(); tick();
        req_rd = 4'b0010;
        tick();
        sd_ack = 1'b1;
        tick();
        RESET = 1'b1;
        #1;
        chk("t6_reset_outputs", 64'({grant, sd_rd, sd_wr, sd_lba, tmo_err, busy, drv_ack}), 64'd0);
        sd_ack = 1'b0;
        tick();
        RESET = 1'b0;
        req_rd = 4'b0011;
        host(1, 4'b0001);
        host(1, 4'b0010);

        repeat (5) tick();
        chk("sb_drain", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_blk_arbiter.md
SD_BLK_ARBITER -- requirements
Module: sd_blk_arbiter

Interface
REQ-001 Parameter: TMO_W, default 24, width of the ack-wait watchdog counter; timeout fires after 2^TMO_W-1 cycles.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 req_rd  input  4  per-drive sector read request, level, bit n = drive n.
REQ-005 req_wr  input  4  per-drive sector write request, level.
REQ-006 req_lba  input  4x32  per-drive sector LBA, valid while that drive's request is high.
REQ-007 drv_buff_din  input  4x8  per-drive buffer read data, used for writes to SD.
REQ-008 drv_ack  output  4  per-drive ack; only the granted bit can be high.
REQ-009 sd_rd  output  1  shared SD read request.
REQ-010 sd_wr  output  1  shared SD write request.
REQ-011 sd_lba  output  32  shared SD LBA.
REQ-012 sd_ack  input  1  shared SD ack from host.
REQ-013 sd_buff_din  output  8  shared buffer data to host = drv_buff_din[grant], combinational.
REQ-014 grant  output  2  index of the granted drive.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 tmo_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-017 States IDLE, ISSUE, XFER, RECOVER, encoded in 2 bits.
REQ-018 Request vector r[n] = req_rd[n] | req_wr[n].
REQ-019 IDLE with r != 0: select the first set bit searching upward from (last+1) mod 4 (round-robin), latch grant, latch op (read if req_rd[n], else write; read wins when both are set), latch sd_lba <= req_lba[n], then go to ISSUE.
REQ-020 ISSUE: sd_rd = op==read, sd_wr = op==write; go to XFER on the first cycle sd_ack=1.
REQ-021 XFER: sd_rd = sd_wr = 0; drv_ack[grant] = sd_ack (combinational); on sd_ack=0 set last <= grant and go to IDLE.
REQ-022 Latency: sd_rd/sd_wr rise exactly 1 cycle after the IDLE cycle in which the request is seen; at most 1 idle cycle separates two back-to-back grants.
REQ-023 Cancel: in ISSUE, if r[grant]=0 and sd_ack=0, go to IDLE without updating last and without acking.
REQ-024 Watchdog: the counter clears on entry to ISSUE and increments each ISSUE cycle; at all-ones, pulse tmo_err, drop sd_rd/sd_wr, and go to RECOVER.
REQ-025 RECOVER: wait for sd_ack=0 and r[grant]=0, then set last <= grant and go to IDLE; drv_ack stays 0 throughout.
REQ-026 sd_lba, grant and op are frozen outside IDLE; requests from other drives are ignored until the current grant returns to IDLE.
REQ-027 If sd_ack is high in IDLE or RECOVER, it is ignored and no drv_ack bit is raised.
REQ-028 drv_ack bits for non-granted drives are always 0.

Reset
REQ-029 While RESET is high: state=IDLE, last=3 (so drive 0 is searched first), grant=0, sd_rd=0, sd_wr=0, sd_lba=0, tmo_err=0, busy=0, drv_ack=0, counter=0.
REQ-030 RESET asserted mid-transfer aborts immediately, with no ack completion; after release the block arbitrates fresh.

Verification
REQ-031 req_rd=0001, lba0=0x12: next cycle sd_rd=1, sd_lba=0x12, grant=0; ack high 3 cycles -> drv_ack=0001 for those 3 cycles, sd_rd drops the cycle after ack rises, busy falls after ack falls.
REQ-032 req_wr=1111 held, each ack 2 cycles: grants in order 0,1,2,3,0 with sd_wr high each time and lba tracking req_lba[grant].
REQ-033 req_rd[2]=req_wr[2]=1: sd_rd=1 and sd_wr=0.
REQ-034 TMO_W=4, req_rd=0010, sd_ack never rises: tmo_err pulses after 15 ISSUE cycles, sd_rd=0, the block waits in RECOVER until req_rd[1]=0, then next grant goes to drive 2 if requested.
REQ-035 req_wr[3] dropped in ISSUE before ack: returns to IDLE, drv_ack stays 0, and a subsequent req from drive 3 is granted first.
REQ-036 RESET pulsed during XFER: all outputs are 0 that cycle, and a new request is granted starting from drive 0.
